// File: rtl/pwrseq_step_ctrl.sv
`default_nettype none
// ============================================================================
// pwrseq_step_ctrl - per-stage power sequencing controller (gate, pgood
// timeout, check-live delay, power-off delay, fault capture). Rev 1.0
// ============================================================================
module pwrseq_step_ctrl #(
  parameter int PGD_TIMEOUT_US = 10000,
  parameter int CHKLIVE_DLY_US = 1000,
  parameter int OFF_DLY_US     = 500,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       t1us,
  input  logic       pwr_on_req,
  input  logic       pwr_off_req,
  input  logic       sm_critical_fail,
  input  logic       pgd_so_far,
  input  logic       mod_fault,
  output logic       gate_en,
  output logic       chklive_en,
  output logic       chklive_dis,
  output logic       pwrdis_en,
  output logic       fault_clear,
  output logic       on_done,
  output logic       off_done,
  output logic       step_fault,
  output logic [1:0] fail_code,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_PGD = 3'd1,
    CHK_DLY  = 3'd2,
    ON       = 3'd3,
    OFF_DIS  = 3'd4,
    OFF_WAIT = 3'd5,
    FAULT    = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] PGD_LAST = CNT_W'(PGD_TIMEOUT_US - 1);
  localparam logic [CNT_W-1:0] CHK_LAST = CNT_W'(CHKLIVE_DLY_US - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_DLY_US - 1);

  state_t           cur_st;
  state_t           nxt_st;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       nxt_code;
  logic             nxt_clear;
  logic             nxt_off_done;
  logic             tick_count;
  logic             pgd_exp;
  logic             chk_exp;
  logic             off_exp;

  assign pgd_exp    = t1us && (cnt == PGD_LAST);
  assign chk_exp    = t1us && (cnt == CHK_LAST);
  assign off_exp    = t1us && (cnt == OFF_LAST);
  assign tick_count = t1us && ((cur_st == WAIT_PGD) || (cur_st == CHK_DLY) ||
                               (cur_st == OFF_WAIT));

  always_comb begin
    nxt_st       = cur_st;
    nxt_code     = fail_code;
    nxt_clear    = 1'b0;
    nxt_off_done = 1'b0;
    case (cur_st)
      IDLE: begin
        if (pwr_on_req && !pwr_off_req) begin
          nxt_st    = WAIT_PGD;
          nxt_clear = 1'b1;
          nxt_code  = 2'd0;
        end
      end
      WAIT_PGD: begin
        if (sm_critical_fail) begin
          nxt_st   = FAULT;
          nxt_code = 2'd0;
        end else if (pwr_off_req) begin
          nxt_st = OFF_DIS;
        end else if (pgd_so_far) begin
          nxt_st = CHK_DLY;
        end else if (pgd_exp) begin
          nxt_st   = FAULT;
          nxt_code = 2'd1;
        end
      end
      CHK_DLY: begin
        if (sm_critical_fail) begin
          nxt_st   = FAULT;
          nxt_code = 2'd0;
        end else if (pwr_off_req) begin
          nxt_st = OFF_DIS;
        end else if (!pgd_so_far) begin
          nxt_st   = FAULT;
          nxt_code = 2'd2;
        end else if (chk_exp) begin
          nxt_st = ON;
        end
      end
      ON: begin
        if (sm_critical_fail) begin
          nxt_st   = FAULT;
          nxt_code = 2'd0;
        end else if (mod_fault) begin
          nxt_st   = FAULT;
          nxt_code = 2'd3;
        end else if (pwr_off_req) begin
          nxt_st = OFF_DIS;
        end
      end
      OFF_DIS: nxt_st = OFF_WAIT;
      OFF_WAIT: begin
        if (off_exp) begin
          nxt_st       = IDLE;
          nxt_off_done = 1'b1;
        end
      end
      FAULT: begin
        if (pwr_off_req) nxt_st = OFF_WAIT;
      end
      default: nxt_st = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they move with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_st      <= IDLE;
      cnt         <= '0;
      gate_en     <= 1'b0;
      chklive_en  <= 1'b0;
      chklive_dis <= 1'b1;
      pwrdis_en   <= 1'b0;
      fault_clear <= 1'b0;
      on_done     <= 1'b0;
      off_done    <= 1'b0;
      step_fault  <= 1'b0;
      fail_code   <= 2'd0;
    end else begin
      cur_st <= nxt_st;
      if (nxt_st != cur_st) begin
        cnt <= '0;
      end else if (tick_count) begin
        cnt <= cnt + CNT_W'(1);
      end
      gate_en     <= (nxt_st == WAIT_PGD) || (nxt_st == CHK_DLY) ||
                     (nxt_st == ON) || (nxt_st == OFF_DIS);
      chklive_en  <= (nxt_st == ON);
      chklive_dis <= (nxt_st == IDLE) || (nxt_st == OFF_DIS) ||
                     (nxt_st == OFF_WAIT) || (nxt_st == FAULT);
      pwrdis_en   <= (nxt_st == ON) || (nxt_st == FAULT);
      fault_clear <= nxt_clear;
      on_done     <= (nxt_st == ON);
      off_done    <= nxt_off_done;
      step_fault  <= (nxt_st == FAULT);
      fail_code   <= nxt_code;
    end
  end

  assign state = cur_st;

endmodule
`default_nettype wire

// File: tb/tb_pwrseq_step_ctrl.sv
`default_nettype none
// tb_pwrseq_step_ctrl - directed scenarios plus randomized traffic, checked
// every cycle against a tick-countdown reference model of the stage sequencer.
module tb_pwrseq_step_ctrl;
  localparam int PGD_TO  = 60;
  localparam int CHK_DLY = 4;
  localparam int OFF_DLY = 5;
  localparam int S_IDLE = 0, S_WAIT = 1, S_CHK = 2, S_ON = 3, S_OFFD = 4, S_OFFW = 5, S_FAULT = 6;
  localparam logic [12:0] RESET_VEC = 13'b0010_0000_00_000;

  logic clk = 1'b0, reset = 1'b0, t1us = 1'b0;
  logic pwr_on_req = 1'b0, pwr_off_req = 1'b0, sm_critical_fail = 1'b0;
  logic pgd_so_far = 1'b0, mod_fault = 1'b0;
  logic gate_en, chklive_en, chklive_dis, pwrdis_en, fault_clear;
  logic on_done, off_done, step_fault;
  logic [1:0] fail_code;
  logic [2:0] state;

  int checks = 0, failures = 0;
  int m_st = S_IDLE, m_left = 0, m_code = 0;
  bit m_fc = 1'b0, m_od = 1'b0;
  int cyc = 0, seg_state = -1, seg_ticks = 0;
  bit auto_tick = 1'b1;

  pwrseq_step_ctrl #(
    .PGD_TIMEOUT_US(PGD_TO), .CHKLIVE_DLY_US(CHK_DLY), .OFF_DLY_US(OFF_DLY), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .t1us(t1us), .pwr_on_req(pwr_on_req),
    .pwr_off_req(pwr_off_req), .sm_critical_fail(sm_critical_fail),
    .pgd_so_far(pgd_so_far), .mod_fault(mod_fault), .gate_en(gate_en),
    .chklive_en(chklive_en), .chklive_dis(chklive_dis), .pwrdis_en(pwrdis_en),
    .fault_clear(fault_clear), .on_done(on_done), .off_done(off_done),
    .step_fault(step_fault), .fail_code(fail_code), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic logic [12:0] dut_vec();
    return {gate_en, chklive_en, chklive_dis, pwrdis_en, fault_clear, on_done,
            off_done, step_fault, fail_code, state};
  endfunction

  // Expected pins follow from which phase the stage is in after the edge.
  function automatic logic [12:0] exp_vec();
    logic g, ce, cd, pd, od, sf;
    g  = (m_st == S_WAIT) || (m_st == S_CHK) || (m_st == S_ON) || (m_st == S_OFFD);
    ce = (m_st == S_ON);
    cd = !g || (m_st == S_OFFD);
    pd = (m_st == S_ON) || (m_st == S_FAULT);
    od = (m_st == S_ON);
    sf = (m_st == S_FAULT);
    return {g, ce, cd, pd, m_fc, od, m_od, sf, 2'(m_code), 3'(m_st)};
  endfunction

  function automatic int delay_of(input int st);
    if (st == S_WAIT) return PGD_TO;
    if (st == S_CHK)  return CHK_DLY;
    if (st == S_OFFW) return OFF_DLY;
    return 0;
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_left = 0; m_code = 0; m_fc = 1'b0; m_od = 1'b0;
  endtask

  // m_left counts the ticks still owed; the tick that finds one left is the expiry.
  task automatic model_clk();
    int nx;
    bit expd;
    nx = m_st;
    expd = t1us && (m_left == 1);
    m_fc = 1'b0; m_od = 1'b0;
    case (m_st)
      S_IDLE: if (pwr_on_req && !pwr_off_req) begin nx = S_WAIT; m_fc = 1'b1; m_code = 0; end
      S_WAIT: begin
        if (sm_critical_fail) begin nx = S_FAULT; m_code = 0; end
        else if (pwr_off_req) nx = S_OFFD;
        else if (pgd_so_far) nx = S_CHK;
        else if (expd) begin nx = S_FAULT; m_code = 1; end
      end
      S_CHK: begin
        if (sm_critical_fail) begin nx = S_FAULT; m_code = 0; end
        else if (pwr_off_req) nx = S_OFFD;
        else if (!pgd_so_far) begin nx = S_FAULT; m_code = 2; end
        else if (expd) nx = S_ON;
      end
      S_ON: begin
        if (sm_critical_fail) begin nx = S_FAULT; m_code = 0; end
        else if (mod_fault) begin nx = S_FAULT; m_code = 3; end
        else if (pwr_off_req) nx = S_OFFD;
      end
      S_OFFD: nx = S_OFFW;
      S_OFFW: if (expd) begin nx = S_IDLE; m_od = 1'b1; end
      S_FAULT: if (pwr_off_req) nx = S_OFFW;
      default: nx = S_IDLE;
    endcase
    if (nx != m_st) m_left = delay_of(nx);
    else if (t1us && m_left > 0) m_left--;
    m_st = nx;
  endtask

  task automatic step();
    int pre;
    if (auto_tick) t1us = (cyc % 3 == 0);
    @(posedge clk);
    cyc++;
    pre = m_st;
    if (reset) model_reset(); else model_clk();
    if (!reset && pre == seg_state && t1us) seg_ticks++;
    #1;
    chk("outputs", dut_vec(), exp_vec());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    model_reset();
    #1;
    chk("reset_vals", dut_vec(), RESET_VEC);
    step(); step();
    reset = 1'b0;

    // Normal power-on: pgood 50 ticks after the gate, then the check-live delay.
    pwr_on_req = 1'b1;
    step();
    chk("start_fault_clear", fault_clear, 1);
    seg_state = S_WAIT; seg_ticks = 0;
    for (int n = 0; n < 400 && seg_ticks < 50; n++) step();
    pgd_so_far = 1'b1;
    step();
    chk("enter_chk_dly", state, S_CHK);
    seg_state = S_CHK; seg_ticks = 0;
    for (int n = 0; n < 100 && !on_done; n++) step();
    chk("on_done_seen", on_done, 1);
    chk("chkdly_ticks", seg_ticks, CHK_DLY);
    chk("chklive_en_on", chklive_en, 1);

    // Module fault while ON, then power-off out of FAULT.
    mod_fault = 1'b1;
    step();
    mod_fault = 1'b0;
    chk("modfault_code", fail_code, 3);
    chk("modfault_chkdis", chklive_dis, 1);
    chk("modfault_gate", gate_en, 0);
    pwr_on_req = 1'b0; pwr_off_req = 1'b1;
    step();
    pwr_off_req = 1'b0;
    seg_state = S_OFFW; seg_ticks = 0;
    for (int n = 0; n < 100 && !off_done; n++) step();
    chk("fault_off_done", off_done, 1);
    chk("fault_off_ticks", seg_ticks, OFF_DLY);
    chk("code_kept_idle", fail_code, 3);

    // Pgood timeout.
    pgd_so_far = 1'b0; pwr_on_req = 1'b1;
    step();
    chk("code_cleared", fail_code, 0);
    seg_state = S_WAIT; seg_ticks = 0;
    for (int n = 0; n < 400 && !step_fault; n++) step();
    chk("timeout_fault", step_fault, 1);
    chk("timeout_ticks", seg_ticks, PGD_TO);
    chk("timeout_code", fail_code, 1);
    chk("timeout_gate", gate_en, 0);
    pwr_on_req = 1'b0; pwr_off_req = 1'b1;
    step();
    pwr_off_req = 1'b0;
    for (int n = 0; n < 100 && !off_done; n++) step();
    chk("timeout_off_done", off_done, 1);
    step();
    chk("timeout_idle", state, S_IDLE);
    chk("timeout_code_idle", fail_code, 1);

    // Pgood lost during the check-live delay.
    pwr_on_req = 1'b1;
    step();
    pgd_so_far = 1'b1;
    step();
    pgd_so_far = 1'b0;
    step();
    chk("pgd_lost_code", fail_code, 2);
    pwr_on_req = 1'b0; pwr_off_req = 1'b1;
    step();
    pwr_off_req = 1'b0;
    for (int n = 0; n < 100 && !off_done; n++) step();

    // Orderly off from ON; an on request during OFF_WAIT must be ignored.
    pwr_on_req = 1'b1; pgd_so_far = 1'b1;
    for (int n = 0; n < 300 && !on_done; n++) step();
    chk("reach_on", on_done, 1);
    pwr_on_req = 1'b0; pwr_off_req = 1'b1;
    step();
    pwr_off_req = 1'b0;
    chk("offdis_gate", gate_en, 1);
    chk("offdis_chkdis", chklive_dis, 1);
    chk("offdis_chken", chklive_en, 0);
    pwr_on_req = 1'b1;
    step();
    chk("offwait_gate", gate_en, 0);
    seg_state = S_OFFW; seg_ticks = 1;
    if (!t1us) seg_ticks = 0;
    for (int n = 0; n < 100 && !off_done; n++) step();
    chk("on_off_done", off_done, 1);
    chk("on_off_ticks", seg_ticks, OFF_DLY);
    pwr_on_req = 1'b0;
    step();

    // Simultaneous events.
    pwr_on_req = 1'b1; pwr_off_req = 1'b1; pgd_so_far = 1'b0;
    step(); step();
    chk("both_req_idle", state, S_IDLE);
    pwr_off_req = 1'b0;
    step();
    sm_critical_fail = 1'b1; pgd_so_far = 1'b1;
    step();
    sm_critical_fail = 1'b0;
    chk("crit_vs_pgd_state", state, S_FAULT);
    chk("crit_vs_pgd_code", fail_code, 0);
    pwr_on_req = 1'b0; pwr_off_req = 1'b1;
    step();
    pwr_off_req = 1'b0;
    for (int n = 0; n < 100 && !off_done; n++) step();

    // Asynchronous reset while ON, then restart with on_req held.
    pwr_on_req = 1'b1;
    for (int n = 0; n < 300 && !on_done; n++) step();
    chk("reach_on_2", on_done, 1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_vals", dut_vec(), RESET_VEC);
    model_reset();
    step();
    reset = 1'b0;
    step();
    chk("restart_state", state, S_WAIT);
    chk("restart_clear", fault_clear, 1);

    // Randomized traffic.
    auto_tick = 1'b0;
    seg_state = -1;
    for (int n = 0; n < 5000; n++) begin
      pwr_on_req       = ($urandom_range(0, 3) != 0);
      pwr_off_req      = ($urandom_range(0, 9) == 0);
      sm_critical_fail = ($urandom_range(0, 59) == 0);
      mod_fault        = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 11) == 0) pgd_so_far = ~pgd_so_far;
      t1us             = ($urandom_range(0, 2) == 0);
      reset            = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
